// File: rtl/time_set_ctrl.sv
// Time/alarm set sequencer: selects the displayed time, steps through hour/minute
// edit fields, blinks the active field and issues commit strobes.
module time_set_ctrl #(
   parameter int BLINK_CYCLES   = 50_000_000,
   parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        btn_mode_i,
   input  logic        btn_up_i,
   input  logic        btn_down_i,
   input  logic [19:0] cur_time_i,
   input  logic [19:0] alarm_time_i,
   output logic [19:0] disp_time_o,
   output logic [1:0]  field_blank_o,
   output logic        editing_o,
   output logic [19:0] new_time_o,
   output logic        load_time_o,
   output logic        load_alarm_o
);

   localparam int BW = (BLINK_CYCLES   > 1) ? $clog2(BLINK_CYCLES)   : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {SHOW, T_HOUR, T_MIN, A_HOUR, A_MIN} state_t;

   state_t        state_q, state_d;
   logic [19:0]   buf_q, buf_d;
   logic [19:0]   disp_q, disp_d;
   logic [19:0]   new_q, new_d;
   logic [1:0]    blank_q, blank_d;
   logic          edit_q, edit_d;
   logic          lt_q, lt_d;
   logic          la_q, la_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;
   logic [TW-1:0] to_q, to_d;
   logic          any_btn, step_en;

   // BCD hour step over 00..23, wrapping both ways
   function automatic logic [5:0] hr_step(input logic [5:0] h, input logic up);
      logic [1:0] t;
      logic [3:0] u;
      t = h[5:4];
      u = h[3:0];
      if (up) begin
         if (t == 2'd2 && u == 4'd3) begin t = 2'd0; u = 4'd0; end
         else if (u == 4'd9)          begin t = t + 2'd1; u = 4'd0; end
         else                              u = u + 4'd1;
      end else begin
         if (t == 2'd0 && u == 4'd0)  begin t = 2'd2; u = 4'd3; end
         else if (u == 4'd0)          begin t = t - 2'd1; u = 4'd9; end
         else                              u = u - 4'd1;
      end
      return {t, u};
   endfunction

   // BCD minute step over 00..59; never carries into hours
   function automatic logic [6:0] mn_step(input logic [6:0] m, input logic up);
      logic [2:0] t;
      logic [3:0] u;
      t = m[6:4];
      u = m[3:0];
      if (up) begin
         if (u == 4'd9) begin
            u = 4'd0;
            t = (t == 3'd5) ? 3'd0 : t + 3'd1;
         end else u = u + 4'd1;
      end else begin
         if (u == 4'd0) begin
            u = 4'd9;
            t = (t == 3'd0) ? 3'd5 : t - 3'd1;
         end else u = u - 4'd1;
      end
      return {t, u};
   endfunction

   always_comb begin
      any_btn = btn_mode_i | btn_up_i | btn_down_i;
      step_en = (btn_up_i ^ btn_down_i) & ~btn_mode_i;
      state_d = state_q;
      buf_d   = buf_q;
      new_d   = new_q;
      lt_d    = 1'b0;
      la_d    = 1'b0;
      to_d    = '0;

      // Any press restarts the blink so the edited field is visible at once
      if (any_btn) begin
         blink_d = '0;
         phase_d = 1'b0;
      end else if (blink_q == BW'(BLINK_CYCLES - 1)) begin
         blink_d = '0;
         phase_d = ~phase_q;
      end else begin
         blink_d = blink_q + BW'(1);
         phase_d = phase_q;
      end

      if (state_q != SHOW && !any_btn) begin
         if (to_q == TW'(TIMEOUT_CYCLES - 1)) state_d = SHOW;
         else                                 to_d    = to_q + TW'(1);
      end

      case (state_q)
         SHOW: if (btn_mode_i) begin
            buf_d   = {cur_time_i[19:7], 7'd0};
            state_d = T_HOUR;
         end
         T_HOUR, A_HOUR: begin
            if (btn_mode_i)   state_d = (state_q == T_HOUR) ? T_MIN : A_MIN;
            else if (step_en) buf_d[19:14] = hr_step(buf_q[19:14], btn_up_i);
         end
         T_MIN: begin
            if (btn_mode_i) begin
               new_d   = buf_q;
               lt_d    = 1'b1;
               buf_d   = {alarm_time_i[19:7], 7'd0};
               state_d = A_HOUR;
            end else if (step_en) buf_d[13:7] = mn_step(buf_q[13:7], btn_up_i);
         end
         A_MIN: begin
            if (btn_mode_i) begin
               new_d   = buf_q;
               la_d    = 1'b1;
               state_d = SHOW;
            end else if (step_en) buf_d[13:7] = mn_step(buf_q[13:7], btn_up_i);
         end
         default: state_d = SHOW;
      endcase

      edit_d = (state_d != SHOW);
      disp_d = edit_d ? buf_d : cur_time_i;
      case (state_d)
         T_HOUR, A_HOUR: blank_d = {phase_d, 1'b0};
         T_MIN, A_MIN:   blank_d = {1'b0, phase_d};
         default:        blank_d = 2'b00;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= SHOW;
         buf_q   <= '0;
         disp_q  <= '0;
         new_q   <= '0;
         blank_q <= '0;
         edit_q  <= 1'b0;
         lt_q    <= 1'b0;
         la_q    <= 1'b0;
         blink_q <= '0;
         phase_q <= 1'b0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         disp_q  <= disp_d;
         new_q   <= new_d;
         blank_q <= blank_d;
         edit_q  <= edit_d;
         lt_q    <= lt_d;
         la_q    <= la_d;
         blink_q <= blink_d;
         phase_q <= phase_d;
         to_q    <= to_d;
      end
   end

   assign disp_time_o   = disp_q;
   assign field_blank_o = blank_q;
   assign editing_o     = edit_q;
   assign new_time_o    = new_q;
   assign load_time_o   = lt_q;
   assign load_alarm_o  = la_q;

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- User-interface sequencer in front of the display datapath.
- Selects what drives the 20-bit display time: live clock time, or an edit buffer while the user sets the time or the alarm.
- Steps through the hour and minute fields on button presses and produces blink masks for the field being edited.
- Issues single-cycle commit strobes to the timekeeping counter and the alarm register.

Parameters:
- BLINK_CYCLES, 50_000_000: clock cycles per blink half-period (0.5 s at 100 MHz).
- TIMEOUT_CYCLES, 1_000_000_000: idle cycles before an edit is abandoned (10 s at 100 MHz).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- btn_mode  in  1  debounced single-cycle pulse; advances the edit field.
- btn_up  in  1  debounced single-cycle pulse; increments the active field.
- btn_down  in  1  debounced single-cycle pulse; decrements the active field.
- cur_time  in  20  live time, BCD {h10[1:0],h1[3:0],m10[2:0],m1[3:0],s10[2:0],s1[3:0]}.
- alarm_time  in  20  stored alarm, same format.
- disp_time  out  20  time to the display block, same format.
- field_blank  out  2  {hour_blank, min_blank}; 1 means the field is blanked this phase.
- editing  out  1  high in any edit state.
- new_time  out  20  commit value for the clock or alarm.
- load_time  out  1  1-cycle strobe: the clock counter loads new_time.
- load_alarm  out  1  1-cycle strobe: the alarm register loads new_time.

Behaviour:
- All outputs are registered and change one cycle after the causing input.
- Reset (asynchronous, any state, including mid-edit) forces:
  - state to SHOW;
  - edit buffer, disp_time, new_time, field_blank, blink and timeout counters, and blink phase to 0;
  - load_time, load_alarm, editing to 0.
  - No commit strobe is issued on reset.
- States are SHOW, T_HOUR, T_MIN, A_HOUR, A_MIN.
- SHOW:
  - disp_time = cur_time (one-cycle latency); field_blank = 00; editing = 0.
  - btn_mode loads the edit buffer with cur_time, seconds forced to 00, then goes to T_HOUR.
- T_HOUR + btn_mode -> T_MIN.
- T_MIN + btn_mode:
  - new_time = edit buffer and load_time = 1 for exactly one cycle.
  - Edit buffer loads alarm_time, seconds forced to 00; go to A_HOUR.
- A_HOUR + btn_mode -> A_MIN.
- A_MIN + btn_mode: new_time = edit buffer, load_alarm = 1 for one cycle; go to SHOW.
- In edit states: disp_time = edit buffer; editing = 1.
- btn_up / btn_down in an hour state:
  - BCD increment or decrement, range 00..23.
  - Wraps: 23 + 1 = 00, 00 - 1 = 23; units carry/borrow correctly (09 + 1 = 10, 10 - 1 = 09, 19 + 1 = 20).
- btn_up / btn_down in a minute state:
  - BCD range 00..59; wraps 59 + 1 = 00, 00 - 1 = 59.
  - Minutes never carry into hours.
- btn_up / btn_down in SHOW are ignored.
- Simultaneous events:
  - btn_up and btn_down together: no change; still counts as activity.
  - btn_mode together with up or down: mode wins and the value change is dropped.
- Blink:
  - The counter counts 0..BLINK_CYCLES-1 and toggles phase at wrap.
  - The active field's blank bit = phase; the other bit is 0.
  - Any button press clears the counter and phase, so the field shows immediately.
- Timeout:
  - The counter clears on any button and increments each cycle in edit states.
  - Reaching TIMEOUT_CYCLES-1 returns to SHOW with no strobe (edit discarded).
  - An alarm edit abandoned this way keeps the already-committed time.
- Commit strobes are never both high in the same cycle and never high in consecutive cycles.

Test Plan:
- Reset asserted mid-A_MIN with buffer 07:45 -> next edge: state SHOW, load_alarm 0, disp_time follows cur_time, field_blank 00.
- cur_time 23:58:31, mode, up -> disp_time 00:58:00, field_blank 10 or 00 per phase, editing 1.
- In T_MIN, buffer 12:00: down -> 12:59; up twice -> 12:01; mode -> new_time 12:01:00, load_time high exactly one cycle.
- BLINK_CYCLES=4, TIMEOUT_CYCLES=20 in T_HOUR, no buttons:
  - field_blank toggles 10/00 every 4 cycles;
  - state returns to SHOW after 20 cycles;
  - no strobe is issued.
- btn_up and btn_down in the same cycle at 09 -> value stays 09; timeout counter clears.
- btn_mode with btn_up in A_HOUR at 06 -> state A_MIN, hour stays 06.
